// File: rtl/mix_col_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mix_col_pkg
// Description : Shared FSM encoding, GF(2^8) constants and helpers for the
//               iterative MixColumns / InvMixColumns engine.
// Revision    : 1.0 - initial release
// ============================================================================
package mix_col_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  c_gf_poly  = 8'h1B;
    // One nibble per byte position a_i, a_(i+1), a_(i+2), a_(i+3).
    localparam logic [15:0] c_fwd_coef = 16'h2311;
    localparam logic [15:0] c_inv_coef = 16'hEBD9;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? c_gf_poly : 8'h00);
    endfunction

    // Every coefficient fits in 4 bits, so three chained doublings suffice.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] coef);
        logic [7:0] w_pow;
        logic [7:0] w_acc;
        w_pow = a;
        w_acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (coef[k]) w_acc = w_acc ^ w_pow;
            w_pow = xtime(w_pow);
        end
        return w_acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_col_word.sv
`default_nettype none
// ============================================================================
// Module      : mix_col_word
// Description : Combinational transform of one 32-bit column, forward or
//               inverse selected by inv.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_col_word
    import mix_col_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [15:0] w_coef;
    logic [7:0]  w_a [4];

    assign w_coef = inv ? c_inv_coef : c_fwd_coef;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_byte
            assign w_a[i] = col_in[31-8*i -: 8];
            assign col_out[31-8*i -: 8] = gf_mul(w_a[i],         w_coef[15:12])
                                        ^ gf_mul(w_a[(i+1) % 4], w_coef[11:8])
                                        ^ gf_mul(w_a[(i+2) % 4], w_coef[7:4])
                                        ^ gf_mul(w_a[(i+3) % 4], w_coef[3:0]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mix_col_iter.sv
`default_nettype none
// ============================================================================
// Module      : mix_col_iter
// Description : Iterative (Inv)MixColumns over an NCOL-column state, one
//               column per clock, valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_col_iter
    import mix_col_pkg::*;
#(
    parameter int NCOL   = 8,
    parameter int INV_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*NCOL-1:0]   in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*NCOL-1:0]   out_data,
    output logic                 busy
);

    localparam int               COL_W      = $clog2(NCOL);
    localparam logic [COL_W-1:0] c_last_col = COL_W'(NCOL - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COL_W-1:0]   r_col;
    logic               r_mode;
    logic [32*NCOL-1:0] r_work;
    logic [31:0]        w_cols [NCOL];
    logic [31:0]        w_col_new;
    logic               w_accept;
    logic               w_last;
    logic               w_inv_in;

    assign w_inv_in  = (INV_EN != 0) ? in_inv : 1'b0;
    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_last    = (r_col == c_last_col);

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_work;

    generate
        for (genvar c = 0; c < NCOL; c++) begin : g_col
            assign w_cols[c] = r_work[32*(NCOL-c)-1 -: 32];
        end
    endgenerate

    mix_col_word u_word (
        .col_in  (w_cols[r_col]),
        .inv     (r_mode),
        .col_out (w_col_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_col  <= '0;
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_work <= in_data;
            r_col  <= '0;
            r_mode <= w_inv_in;
        end else if (r_state == ST_RUN) begin
            for (int c = 0; c < NCOL; c++) begin
                if (r_col == COL_W'(c)) r_work[32*(NCOL-c)-1 -: 32] <= w_col_new;
            end
            // Wrap explicitly so non-power-of-two NCOL never leaves the legal range.
            r_col <= w_last ? '0 : r_col + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_col_iter.sv
`timescale 1ns/1ps
// Directed-vector bench: NCOL=8 inverse-capable instance plus an NCOL=4
// forward-only instance.
module tb_mix_col_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_inv, out_ready;
    logic [255:0] in_data;
    logic         in_ready, out_valid, busy;
    logic [255:0] out_data;

    logic         v4_in_valid, v4_in_inv, v4_out_ready;
    logic [127:0] v4_in_data;
    logic         v4_in_ready, v4_out_valid, v4_busy;
    logic [127:0] v4_out_data;

    mix_col_iter #(.NCOL(8), .INV_EN(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    mix_col_iter #(.NCOL(4), .INV_EN(0)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
        .in_data(v4_in_data), .in_inv(v4_in_inv), .out_valid(v4_out_valid),
        .out_ready(v4_out_ready), .out_data(v4_out_data), .busy(v4_busy)
    );

    typedef struct {
        logic         inv;
        logic [255:0] din;
        logic [255:0] dout;
    } vec_t;

    vec_t vecs [5];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run8(input vec_t v, input string name);
        int cyc;
        in_data  = v.din;
        in_inv   = v.inv;
        in_valid = 1'b1;
        check({name, " in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~v.din;
        in_inv   = ~v.inv;
        check({name, " busy/ready in RUN"}, {busy, in_ready}, 2'b10);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, cyc, 8);
        check({name, " data"}, out_data, v.dout);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " back to IDLE"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    task automatic run4(input logic inv, input logic [127:0] din, input logic [127:0] dout,
                        input string name);
        int cyc;
        v4_in_data  = din;
        v4_in_inv   = inv;
        v4_in_valid = 1'b1;
        @(posedge clk); #1;
        v4_in_valid = 1'b0;
        v4_in_data  = '0;
        cyc = 0;
        while (!v4_out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, cyc, 4);
        check({name, " data"}, v4_out_data, dout);
        v4_out_ready = 1'b1;
        @(posedge clk); #1;
        v4_out_ready = 1'b0;
        check({name, " back to IDLE"}, {v4_out_valid, v4_in_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, k, r, ok;
        int acc_cyc [3];
        logic acc_now, out_now;

        vecs[0] = '{1'b0,
            {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6,
             32'hd4d4d4d5, 32'h2d26314c, 32'h80000000, 32'h00000000},
            {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6,
             32'hd5d5d7d6, 32'h4d7ebdf8, 32'h1b80809b, 32'h00000000}};
        vecs[1] = '{1'b1, vecs[0].dout, vecs[0].din};
        vecs[2] = '{1'b1, {8{32'h8e4da1bc}}, {8{32'hdb135345}}};
        vecs[3] = '{1'b0, {8{32'hdb135345}}, {8{32'h8e4da1bc}}};
        vecs[4] = '{1'b1,
            {32'h046681e5, 32'h80000000, 32'hffffffff, 32'h00000000,
             32'hd5d5d7d6, 32'h9fdc589d, 32'h12121212, 32'hc6c6c6c6},
            {32'hd4bf5d30, 32'h41ecdaf7, 32'hffffffff, 32'h00000000,
             32'hd4d4d4d5, 32'hf20a225c, 32'h12121212, 32'hc6c6c6c6}};

        rst = 1'b1;
        in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = '0;
        v4_in_valid = 1'b0; v4_in_inv = 1'b0; v4_out_ready = 1'b0; v4_in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset flags", {in_ready, out_valid, busy}, 3'b100);
        check("reset out_data", out_data, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run8(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the third column is being transformed.
        in_data = vecs[0].din; in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun rst flags", {in_ready, out_valid, busy}, 3'b100);
        check("midrun rst out_data", out_data, '0);
        run8(vecs[1], "after rst");

        // Output stall with out_ready low for 10 cycles.
        in_data = vecs[2].din; in_inv = vecs[2].inv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok = 1;
        in_valid = 1'b1;
        in_data  = vecs[0].din;
        for (int i = 0; i < 10; i++) begin
            if (out_data !== vecs[2].dout || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stall stable", ok, 1);
        check("stall data", out_data, vecs[2].dout);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall release", {out_valid, in_ready}, 2'b01);

        // Back-to-back with in_valid and out_ready held high.
        k = 0; r = 0; cyc = 0;
        acc_cyc = '{0, 0, 0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vecs[0].din;
        in_inv    = vecs[0].inv;
        while (r < 3 && cyc < 100) begin
            acc_now = in_valid && in_ready;
            out_now = out_valid;
            if (out_now) begin
                check($sformatf("b2b result %0d", r), out_data, vecs[r].dout);
                r++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 3) begin
                    in_data = vecs[k].din;
                    in_inv  = vecs[k].inv;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b result count", r, 3);
        check("b2b spacing 0-1", acc_cyc[1] - acc_cyc[0], 10);
        check("b2b spacing 1-2", acc_cyc[2] - acc_cyc[1], 10);

        // Forward-only 4-column instance.
        run4(1'b0, {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6},
                   {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6}, "n4 fwd");
        run4(1'b1, {32'hd4bf5d30, 32'hdb135345, 32'h80000000, 32'h01010101},
                   {32'h046681e5, 32'h8e4da1bc, 32'h1b80809b, 32'h01010101}, "n4 inv ignored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
